triangle_pwm_gen: RTL and testbench

- Center-aligned PWM generator downstream of the 4-bit up/down (triangle) counter.
- Compares the counter value against a double-buffered duty value.
- Drives a complementary high/low gate pair with programmable dead time.
- Emits a once-per-period valley strobe for software and other stages.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/deadtime_gen.sv | 82 ++++++++
 rtl/triangle_pwm_gen.sv | 73 +++++++
 tb/tb_triangle_pwm_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the center-aligned triangle PWM generator.
package pwm_pkg;

   localparam int CW_DEFAULT = 4;
   localparam int DUTY_MAX   = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_DT_UP,
      S_HI,
      S_DT_DN
   } pwm_state_e;

   function automatic int unsigned clamp_duty(input int unsigned d, input int unsigned dmax);
      return (d > dmax) ? dmax : d;
   endfunction

endpackage

// File: rtl/deadtime_gen.sv
// Complementary gate driver: Moore FSM inserting DEAD both-low cycles on every
// side change; outputs are registered from the next-state decode.
module deadtime_gen
   import pwm_pkg::*;
#(
   parameter int DEAD = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_enable,
   input  logic i_ref,
   output logic o_hi,
   output logic o_lo
);

   // Counter is wide enough for the full DEAD range of 1..15.
   localparam int DW = 4;

   pwm_state_e    r_state, w_state_nxt;
   logic [DW-1:0] r_dcnt, w_dcnt_nxt;
   logic          r_hi, r_lo;
   logic          w_dt_done;

   assign w_dt_done = (r_dcnt == DW'(DEAD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_dcnt  <= '0;
         r_hi    <= 1'b0;
         r_lo    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_hi    <= (w_state_nxt == S_HI);
         r_lo    <= (w_state_nxt == S_LO);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      if (!i_enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_dcnt_nxt  = '0;
               w_state_nxt = i_ref ? S_DT_UP : S_LO;
            end
            S_LO: begin
               if (i_ref) begin
                  w_state_nxt = S_DT_UP;
                  w_dcnt_nxt  = '0;
               end
            end
            // A ref drop mid-dead-time falls straight back to the low side.
            S_DT_UP: begin
               if (!i_ref)         w_state_nxt = S_LO;
               else if (w_dt_done) w_state_nxt = S_HI;
               else                w_dcnt_nxt  = r_dcnt + DW'(1);
            end
            S_HI: begin
               if (!i_ref) begin
                  w_state_nxt = S_DT_DN;
                  w_dcnt_nxt  = '0;
               end
            end
            S_DT_DN: begin
               if (i_ref)          w_state_nxt = S_HI;
               else if (w_dt_done) w_state_nxt = S_LO;
               else                w_dcnt_nxt  = r_dcnt + DW'(1);
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/triangle_pwm_gen.sv
// Center-aligned PWM: double-buffered duty compared against a triangle count,
// complementary gates with dead time, and a once-per-period valley strobe.
module triangle_pwm_gen
   import pwm_pkg::*;
#(
   parameter int CW   = CW_DEFAULT,
   parameter int DEAD = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] count_in,
   input  logic          enable,
   input  logic [CW:0]   duty_in,
   input  logic          duty_load,
   output logic          pwm_hi,
   output logic          pwm_lo,
   output logic          period_pulse,
   output logic [CW:0]   duty_active
);

   localparam int unsigned DUTY_LIM = (CW == CW_DEFAULT) ? DUTY_MAX : (1 << CW);

   logic [CW:0]   r_pending;
   logic          r_pending_vld;
   logic [CW:0]   r_duty_active;
   logic          r_ref;
   logic [CW-1:0] r_prev_count;
   logic          r_period_pulse;

   logic [CW:0]   w_duty_clamped;
   logic          w_valley;

   assign w_duty_clamped = (CW+1)'(clamp_duty(32'(duty_in), DUTY_LIM));
   assign w_valley       = (count_in == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending      <= '0;
         r_pending_vld  <= 1'b0;
         r_duty_active  <= '0;
         r_ref          <= 1'b0;
         r_prev_count   <= '0;
         r_period_pulse <= 1'b0;
      end else begin
         r_prev_count   <= count_in;
         r_ref          <= ({1'b0, count_in} < r_duty_active);
         // Only the 1->0 step marks a valley, so the lone zeros after a counter reset stay quiet.
         r_period_pulse <= w_valley && (r_prev_count == CW'(1));
         if (w_valley && r_pending_vld) begin
            r_duty_active <= r_pending;
            r_pending_vld <= 1'b0;
         end
         // A same-edge load wins over the transfer's clear: old value moves, new one waits.
         if (duty_load) begin
            r_pending     <= w_duty_clamped;
            r_pending_vld <= 1'b1;
         end
      end
   end

   deadtime_gen #(.DEAD(DEAD)) u_deadtime (
      .clk      (clk),
      .reset    (reset),
      .i_enable (enable),
      .i_ref    (r_ref),
      .o_hi     (pwm_hi),
      .o_lo     (pwm_lo)
   );

   assign period_pulse = r_period_pulse;
   assign duty_active  = r_duty_active;

endmodule

// File: tb/tb_triangle_pwm_gen.sv
// Directed bench: per-period gate statistics pushed to a scoreboard and checked
// by a monitor at each valley strobe; dead-time/overlap checked every cycle.
module tb_triangle_pwm_gen;

   typedef struct {
      int hi;
      int lo;
      int both;
      int duty;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, enable, duty_load;
   logic [3:0] count_in;
   logic [4:0] duty_in;
   logic       pwm_hi, pwm_lo, period_pulse;
   logic [4:0] duty_active;
   logic       hi3, lo3, pp3;
   logic [4:0] da3;

   exp_t sb[$];
   exp_t e_m;
   int   total = 0, bad = 0;
   bit   started = 0, d1_phase = 0, w_chg = 0;
   int   w_len = 0, w_hi = 0, w_lo = 0, w_both = 0, w_duty = 0, pcnt = 0;
   int   last2 = 0, gap2 = 0, last3 = 0, gap3 = 0;

   triangle_pwm_gen #(.CW(4), .DEAD(2)) u_dut (
      .clk(clk), .reset(reset), .count_in(count_in), .enable(enable),
      .duty_in(duty_in), .duty_load(duty_load), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
      .period_pulse(period_pulse), .duty_active(duty_active)
   );

   triangle_pwm_gen #(.CW(4), .DEAD(3)) u_d3 (
      .clk(clk), .reset(reset), .count_in(count_in), .enable(enable),
      .duty_in(duty_in), .duty_load(duty_load), .pwm_hi(hi3), .pwm_lo(lo3),
      .period_pulse(pp3), .duty_active(da3)
   );

   always #5 clk = ~clk;

   task automatic tally(input string nm, input bit ok, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic track(input string nm, input logic hi, input logic lo, input int dmin,
                        inout int last, inout int gap);
      int s;
      s = hi ? 2 : (lo ? 1 : 0);
      if (s == 0) gap++;
      else begin
         if (last != 0 && last != s) tally(nm, gap >= dmin, gap, dmin);
         last = s;
         gap  = 0;
      end
   endtask

   // Monitor: windows run from one valley strobe to the next.
   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         started = 0; last2 = 0; gap2 = 0; last3 = 0; gap3 = 0;
      end else begin
         tally("overlap", (pwm_hi & pwm_lo) === 1'b0, int'(pwm_hi & pwm_lo), 0);
         tally("overlap_d3", (hi3 & lo3) === 1'b0, int'(hi3 & lo3), 0);
         track("deadgap", pwm_hi, pwm_lo, 2, last2, gap2);
         track("deadgap_d3", hi3, lo3, 3, last3, gap3);
         if (d1_phase) tally("hi_d3_duty1", hi3 === 1'b0, int'(hi3), 0);
         if (period_pulse === 1'b1) begin
            pcnt++;
            if (started) begin
               if (sb.size() == 0) tally("unexpected_period", 1'b0, 1, 0);
               else begin
                  e_m = sb.pop_front();
                  tally("win_len",  w_len == 32,        w_len,  32);
                  tally("win_hi",   w_hi == e_m.hi,     w_hi,   e_m.hi);
                  tally("win_lo",   w_lo == e_m.lo,     w_lo,   e_m.lo);
                  tally("win_both", w_both == e_m.both, w_both, e_m.both);
                  tally("win_duty", w_duty == e_m.duty, w_duty, e_m.duty);
                  tally("duty_stable", !w_chg,          int'(w_chg), 0);
               end
            end
            started = 1;
            w_len = 0; w_hi = 0; w_lo = 0; w_both = 0; w_chg = 0;
            w_duty = int'(duty_active);
         end
         if (started) begin
            w_len++;
            w_hi   += int'(pwm_hi);
            w_lo   += int'(pwm_lo);
            w_both += int'(!pwm_hi && !pwm_lo);
            if (int'(duty_active) != w_duty) w_chg = 1;
         end
      end
   end

   function automatic logic [3:0] cval(input int i);
      if (i == 0)       return 4'd0;
      else if (i <= 16) return 4'(i - 1);
      else              return 4'(32 - i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int hi, input int lo, input int both, input int duty);
      exp_t e;
      e.hi = hi; e.lo = lo; e.both = both; e.duty = duty;
      sb.push_back(e);
   endtask

   task automatic run_period(input int ld_i, input int ld_v, input int off_lo, input int off_hi);
      for (int i = 0; i < 32; i++) begin
         count_in  = cval(i);
         duty_load = (i == ld_i);
         duty_in   = 5'(ld_v);
         enable    = !(i >= off_lo && i <= off_hi);
         tick();
         if (off_lo >= 0 && i == off_lo - 1) begin
            @(negedge clk);
            tally("hi_before_disable", pwm_hi === 1'b1, int'(pwm_hi), 1);
         end
         if (off_lo >= 0 && i == off_lo) begin
            @(negedge clk);
            tally("hi_after_disable", pwm_hi === 1'b0, int'(pwm_hi), 0);
            tally("lo_after_disable", pwm_lo === 1'b0, int'(pwm_lo), 0);
         end
      end
      duty_load = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      @(negedge clk);
      tally({tag, "_hi"},    pwm_hi === 1'b0,        int'(pwm_hi),       0);
      tally({tag, "_lo"},    pwm_lo === 1'b0,        int'(pwm_lo),       0);
      tally({tag, "_pulse"}, period_pulse === 1'b0,  int'(period_pulse), 0);
      tally({tag, "_duty"},  duty_active === 5'd0,   int'(duty_active),  0);
      tally({tag, "_d3"},    {hi3, lo3, pp3, da3} === 8'd0, int'({hi3, lo3, pp3, da3}), 0);
   endtask

   int pc0;

   initial begin
      reset = 1'b1; enable = 1'b0; duty_load = 1'b0; duty_in = '0; count_in = '0;
      tick(); tick();
      chk_reset("reset");
      reset = 1'b0;

      // Load 8 on the first zero; it transfers on the second zero.
      pc0 = pcnt;
      run_period(0, 8, -1, -1);
      tally("no_pulse_after_reset", pcnt == pc0, pcnt - pc0, 0);
      push(14, 14, 4, 8); run_period(-1, 0, -1, -1);
      push(14, 14, 4, 8); run_period(-1, 0, -1, -1);
      // Load 4 at count 9 rising: duty 8 holds until the next valley.
      push(14, 14, 4, 8); run_period(10, 4, -1, -1);
      push(6, 22, 4, 4);  run_period(-1, 0, -1, -1);
      push(6, 22, 4, 4);  run_period(20, 0, -1, -1);
      push(2, 28, 2, 0);  run_period(-1, 0, -1, -1);
      // 20 clamps to 16.
      push(0, 32, 0, 0);  run_period(20, 20, -1, -1);
      push(28, 2, 2, 16); run_period(-1, 0, -1, -1);
      push(32, 0, 0, 16); run_period(-1, 0, -1, -1);
      push(28, 0, 4, 16); run_period(-1, 0, 10, 11);

      // Reset with a pending duty 4 outstanding.
      for (int i = 0; i < 10; i++) begin
         count_in = cval(i); duty_load = (i == 5); duty_in = 5'd4; enable = 1'b1;
         tick();
      end
      duty_load = 1'b0; count_in = cval(10); reset = 1'b1;
      tick();
      chk_reset("midreset");
      reset = 1'b0;

      pc0 = pcnt;
      run_period(-1, 0, -1, -1);
      tally("no_pulse_after_midreset", pcnt == pc0, pcnt - pc0, 0);
      push(0, 32, 0, 0); run_period(-1, 0, -1, -1);
      push(0, 32, 0, 0); run_period(20, 1, -1, -1);
      d1_phase = 1;
      push(0, 31, 1, 1); run_period(-1, 0, -1, -1);
      push(0, 30, 2, 1); run_period(-1, 0, -1, -1);
      push(0, 30, 2, 1); run_period(-1, 0, -1, -1);
      run_period(-1, 0, -1, -1);
      tick(); tick();
      tally("scoreboard_drained", sb.size() == 0, sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
